// File: rtl/ti_pkg.sv
// Shared types and helpers for the ti arbitration controller.
package ti_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_GRANT   = 2'd2,
      ST_PR_WAIT = 2'd3
   } state_t;

   // Bit width needed to index/count v values, never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/ti_arb_controller_if.sv
// Handshake bundle between ti requesters, TI wrappers, PR logic and the arbiter.
interface ti_arb_controller_if #(
   parameter int unsigned NUM_TI_WRAPPERS = 1,
   parameter int unsigned NUM_REQ         = 2
);
   logic [NUM_REQ-1:0]         ti_req;
   logic [NUM_REQ-1:0]         ti_gnt;
   logic [NUM_TI_WRAPPERS-1:0] wrapper_mask;
   logic [NUM_TI_WRAPPERS-1:0] stop_req;
   logic [NUM_TI_WRAPPERS-1:0] stop_ack;
   logic                       pr_done;
   logic                       decouple;
   logic                       busy;
   logic                       timeout;
   logic [NUM_TI_WRAPPERS-1:0] ack_missing;

   modport master (
      input  ti_req, wrapper_mask, stop_ack, pr_done,
      output ti_gnt, stop_req, decouple, busy, timeout, ack_missing
   );

   modport slave (
      output ti_req, wrapper_mask, stop_ack, pr_done,
      input  ti_gnt, stop_req, decouple, busy, timeout, ack_missing
   );
endinterface

// File: rtl/ti_arb_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   idx
);
   logic [PTR_W:0] cand;
   logic           found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NUM_REQ))
            cand = cand - (PTR_W+1)'(NUM_REQ);
         if (!found && req[cand[PTR_W-1:0]]) begin
            found                  = 1'b1;
            gnt[cand[PTR_W-1:0]]   = 1'b1;
            idx                    = cand[PTR_W-1:0];
         end
      end
   end
endmodule

// File: rtl/ti_arb_controller.sv
// Arbitrates ti requesters, stops the masked TI wrappers and gates PR decoupling.
module ti_arb_controller
   import ti_pkg::*;
#(
   parameter int unsigned NUM_TI_WRAPPERS = 1,
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned ACK_TIMEOUT     = 1024
) (
   input logic                  clk,
   input logic                  rst,
   ti_arb_controller_if.master  bus
);
   localparam int unsigned PTR_W = clog2_min1(NUM_REQ);
   localparam int unsigned CNT_W = clog2_min1(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

   state_t                     state, state_nxt;
   logic [PTR_W-1:0]           ptr_q, owner_q, arb_idx;
   logic [NUM_REQ-1:0]         arb_gnt;
   logic [NUM_TI_WRAPPERS-1:0] mask_q, ack_missing_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       timeout_q;
   logic                       start, rr_adv, tmo, all_ack;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req (bus.ti_req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign all_ack = &(bus.stop_ack | ~mask_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         mask_q        <= '0;
         cnt_q         <= '0;
         ack_missing_q <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         timeout_q <= tmo;
         if (start) begin
            owner_q <= arb_idx;
            mask_q  <= bus.wrapper_mask;
            cnt_q   <= '0;
         end else if (state == ST_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (tmo)
            ack_missing_q <= mask_q & ~bus.stop_ack;
         if (rr_adv)
            ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
   end

   // Full ack is tested before the timeout compare so ack wins a tie.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      rr_adv    = 1'b0;
      tmo       = 1'b0;
      unique case (state)
         ST_IDLE: if (|bus.ti_req) begin
            start     = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (all_ack) begin
               state_nxt = ST_GRANT;
            end else if (ACK_TIMEOUT > 0 && cnt_q == CNT_LAST) begin
               state_nxt = ST_IDLE;
               tmo       = 1'b1;
               rr_adv    = 1'b1;
            end
         end
         ST_GRANT: begin
            if (bus.pr_done) begin
               state_nxt = ST_IDLE;
               rr_adv    = 1'b1;
            end else if (!bus.ti_req[owner_q]) begin
               state_nxt = ST_PR_WAIT;
            end
         end
         ST_PR_WAIT: if (bus.pr_done) begin
            state_nxt = ST_IDLE;
            rr_adv    = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // timeout is registered so it lines up with the freshly captured ack_missing.
   assign bus.stop_req    = (state == ST_WAIT || state == ST_GRANT) ? mask_q : '0;
   assign bus.ti_gnt      = (state == ST_GRANT) ? (NUM_REQ'(1) << owner_q) : '0;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.decouple    = (state == ST_GRANT || state == ST_PR_WAIT) && !bus.pr_done;
   assign bus.timeout     = timeout_q;
   assign bus.ack_missing = ack_missing_q;
endmodule

// File: tb/tb_ti_arb_controller.sv
// Directed-vector bench for ti_arb_controller (2 requesters, 2 wrappers, timeout 8).
module tb_ti_arb_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   ti_arb_controller_if #(.NUM_TI_WRAPPERS(2), .NUM_REQ(2)) bus ();

   ti_arb_controller #(
      .NUM_TI_WRAPPERS (2),
      .NUM_REQ         (2),
      .ACK_TIMEOUT     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // gnt, stop_req, decouple, busy, timeout, ack_missing
   task automatic chk_outs(input string tag, input logic [1:0] gnt, input logic [1:0] sreq,
                           input logic dec, input logic bsy, input logic tmo, input logic [1:0] miss);
      chk_vec({tag, ".gnt"},  32'(bus.ti_gnt),      32'(gnt));
      chk_vec({tag, ".sreq"}, 32'(bus.stop_req),    32'(sreq));
      chk_vec({tag, ".dec"},  32'(bus.decouple),    32'(dec));
      chk_vec({tag, ".busy"}, 32'(bus.busy),        32'(bsy));
      chk_vec({tag, ".tmo"},  32'(bus.timeout),     32'(tmo));
      chk_vec({tag, ".miss"}, 32'(bus.ack_missing), 32'(miss));
   endtask

   initial begin
      bus.ti_req       = '0;
      bus.wrapper_mask = '0;
      bus.stop_ack     = '0;
      bus.pr_done      = 1'b0;
      tick();
      tick();
      chk_outs("rst", 2'b00, 2'b00, 0, 0, 0, 2'b00);
      rst = 1'b0;
      tick();
      chk_outs("idle", 2'b00, 2'b00, 0, 0, 0, 2'b00);

      // Basic transaction: req 0, both wrappers masked, acks after 3 WAIT cycles
      bus.wrapper_mask = 2'b11;
      bus.ti_req       = 2'b01;
      tick();
      chk_outs("wait1", 2'b00, 2'b11, 0, 1, 0, 2'b00);
      tick();
      tick();
      chk_outs("wait3", 2'b00, 2'b11, 0, 1, 0, 2'b00);
      bus.stop_ack = 2'b11;
      tick();
      chk_outs("grant", 2'b01, 2'b11, 1, 1, 0, 2'b00);
      bus.ti_req = 2'b00;
      tick();
      chk_outs("prwait", 2'b00, 2'b00, 1, 1, 0, 2'b00);
      bus.pr_done = 1'b1;
      #1;
      chk_vec("prdone.dec_comb", 32'(bus.decouple), 32'd0);
      tick();
      chk_outs("prdone.idle", 2'b00, 2'b00, 0, 0, 0, 2'b00);
      bus.pr_done  = 1'b0;
      bus.stop_ack = 2'b00;

      // Round-robin from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.ti_req   = 2'b11;
      bus.stop_ack = 2'b11;
      tick();
      tick();
      chk_outs("rr1", 2'b01, 2'b11, 1, 1, 0, 2'b00);
      bus.pr_done = 1'b1;
      tick();
      chk_vec("rr1.idle", 32'(bus.busy), 32'd0);
      bus.pr_done = 1'b0;
      tick();
      tick();
      chk_outs("rr2", 2'b10, 2'b11, 1, 1, 0, 2'b00);
      bus.pr_done = 1'b1;
      tick();
      bus.pr_done  = 1'b0;
      bus.ti_req   = 2'b00;
      bus.stop_ack = 2'b00;

      // Timeout: only wrapper 0 acks; 8 WAIT cycles then IDLE with ack_missing=10
      bus.ti_req   = 2'b01;
      bus.stop_ack = 2'b01;
      tick();
      bus.ti_req = 2'b00;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk_outs($sformatf("tmo.wait%0d", i), 2'b00, 2'b11, 0, 1, 0, 2'b00);
      end
      tick();
      chk_outs("tmo.pulse", 2'b00, 2'b00, 0, 0, 1, 2'b10);
      tick();
      chk_outs("tmo.after", 2'b00, 2'b00, 0, 0, 0, 2'b10);

      // Full ack on the last counted cycle beats the timeout
      bus.ti_req   = 2'b01;
      bus.stop_ack = 2'b00;
      tick();
      bus.ti_req = 2'b00;
      for (int i = 1; i < 8; i++) tick();
      bus.stop_ack = 2'b11;
      bus.ti_req   = 2'b01;
      tick();
      chk_outs("tie.grant", 2'b01, 2'b11, 1, 1, 0, 2'b10);
      bus.pr_done = 1'b1;
      tick();
      bus.pr_done  = 1'b0;
      bus.ti_req   = 2'b00;
      bus.stop_ack = 2'b00;

      // Empty mask: one WAIT cycle, then GRANT without stop requests
      bus.wrapper_mask = 2'b00;
      bus.ti_req       = 2'b10;
      tick();
      chk_outs("m0.wait", 2'b00, 2'b00, 0, 1, 0, 2'b10);
      tick();
      chk_outs("m0.grant", 2'b10, 2'b00, 1, 1, 0, 2'b10);
      bus.pr_done = 1'b1;
      tick();
      chk_outs("m0.idle", 2'b00, 2'b00, 0, 0, 0, 2'b10);
      bus.pr_done = 1'b0;
      bus.ti_req  = 2'b00;

      // Reset while granted
      bus.wrapper_mask = 2'b01;
      bus.stop_ack     = 2'b01;
      bus.ti_req       = 2'b01;
      tick();
      tick();
      chk_outs("rg.grant", 2'b01, 2'b01, 1, 1, 0, 2'b10);
      rst = 1'b1;
      tick();
      chk_outs("rg.reset", 2'b00, 2'b00, 0, 0, 0, 2'b00);
      rst         = 1'b0;
      bus.ti_req  = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/ti_arb_controller.md
TI_ARB_CONTROLLER -- requirements
Module: ti_arb_controller

Interface
REQ-001 SHALL have parameter NUM_TI_WRAPPERS, default 1, number of wrappers stopped per transaction.
REQ-002 SHALL have parameter NUM_REQ, default 2, number of independent ti requesters.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024, max WAIT cycles; 0 disables timeout.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ti_req, input, NUM_REQ, per-requester ti request (level).
REQ-007 SHALL have port ti_gnt, output, NUM_REQ, one-hot grant to owning requester.
REQ-008 SHALL have port wrapper_mask, input, NUM_TI_WRAPPERS, wrappers participating in the next transaction.
REQ-009 SHALL have port stop_req, output, NUM_TI_WRAPPERS, stop request per wrapper.
REQ-010 SHALL have port stop_ack, input, NUM_TI_WRAPPERS, stop acknowledge per wrapper.
REQ-011 SHALL have port pr_done, input, 1, partial-reconfiguration completion pulse/level.
REQ-012 SHALL have port decouple, output, 1, PR decoupler enable.
REQ-013 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse on stop-ack timeout.
REQ-015 SHALL have port ack_missing, output, NUM_TI_WRAPPERS, masked wrappers that had not acked at timeout.

Function
REQ-016 SHALL implement states IDLE, WAIT, GRANT, PR_WAIT; outputs decoded from registered state only (except decouple).
REQ-017 IDLE: when any ti_req high, SHALL pick owner by round-robin from rr pointer, latch owner index and wrapper_mask, go WAIT next cycle.
REQ-018 WAIT: stop_req = latched mask; timeout counter increments each cycle.
REQ-019 WAIT -> GRANT when every masked wrapper has stop_ack high (unmasked acks ignored); latched mask of zero SHALL reach GRANT after one WAIT cycle.
REQ-020 WAIT -> IDLE when counter reaches ACK_TIMEOUT-1 without full ack and ACK_TIMEOUT>0; timeout pulses that transition cycle; ack_missing = mask & ~stop_ack, held until next timeout or reset.
REQ-021 Full ack and timeout in the same cycle: ack SHALL win.
REQ-022 GRANT: stop_req = latched mask, ti_gnt[owner]=1, decouple asserted.
REQ-023 GRANT -> PR_WAIT when ti_req[owner] low; GRANT -> IDLE when pr_done high; pr_done SHALL take priority over both.
REQ-024 PR_WAIT: stop_req=0, ti_gnt=0, decouple asserted; -> IDLE on pr_done.
REQ-025 decouple SHALL equal (state is GRANT or PR_WAIT) AND NOT pr_done (combinational gate).
REQ-026 On any return to IDLE from GRANT/PR_WAIT or via timeout, rr pointer SHALL become owner+1 modulo NUM_REQ.
REQ-027 Requests from non-owners SHALL be ignored until IDLE; owner dropping ti_req in WAIT SHALL NOT abort (requirement on requester: hold until grant).
REQ-028 Timeout counter width SHALL be clog2(ACK_TIMEOUT+1), minimum 1; cleared on WAIT entry.

Reset
REQ-029 Reset SHALL force IDLE, rr pointer 0, counter 0, owner 0, latched mask 0, ack_missing 0.
REQ-030 During/after reset: ti_gnt=0, stop_req=0, decouple=0, busy=0, timeout=0; reset mid-transaction SHALL drop all outputs in the next cycle.

Structure
REQ-031 State encoding localparams and clog2 helper SHALL reside in shared package ti_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 NUM_REQ=2, W=2, mask=11: ti_req=01, acks both after 3 cycles -> stop_req=11 from cycle 1, ti_gnt=01 on cycle after acks, decouple high.
REQ-034 Continue: drop ti_req[0] -> PR_WAIT, stop_req=00, ti_gnt=00, decouple=1; pr_done=1 -> decouple=0 same cycle, IDLE next.
REQ-035 ti_req=11 held over two transactions -> first grant 01, second grant 10 (round-robin).
REQ-036 ACK_TIMEOUT=8, mask=11, only ack[0] -> timeout pulse after 8 WAIT cycles, ack_missing=10, IDLE, no grant.
REQ-037 mask=00 -> GRANT after one WAIT cycle with stop_req=00; pr_done in GRANT -> IDLE directly.
REQ-038 Assert rst in GRANT -> next cycle all outputs 0, busy=0, state IDLE.
